img_load_run_sequencer: RTL
===========================

// Module: img_load_run_sequencer
// PURPOSE
//  Sequencer directly downstream of the control register block: consumes its load/run/valid/imgLength outputs.
//  LOAD phase: each valid pulse becomes one memory write strobe with an incrementing column address.
//  RUN phase: sweeps read addresses 0..len-1, then tracks the convolution pipeline latency.
//  Finally raises end-of-processing back to the control block.
// PARAMETERS
//  ADDR_W   10  width of imgLength and of the read/write address counters
//  RUN_LAT  2   cycles from o_rd_en to the matching o_out_valid (conv pipeline depth, >=1)
// PORTS
//  i_CLK        in   1       system clock, rising edge
//  i_rst        in   1       asynchronous reset, active-low
//  i_valid      in   1       one-cycle data-valid pulse from control block
//  i_load       in   1       image-load mode request (level)
//  i_run        in   1       processing request (level)
//  i_imgLength  in   ADDR_W  image length in columns
//  o_we         out  1       memory write strobe, one cycle per accepted valid
//  o_waddr      out  ADDR_W  write address, valid while o_we=1
//  o_rd_en      out  1       memory read enable during RUN sweep
//  o_raddr      out  ADDR_W  read address, valid while o_rd_en=1
//  o_out_valid  out  1       o_rd_en delayed RUN_LAT cycles (conv output valid)
//  o_EOP        out  1       end of processing, level, to control block EOP input
//  o_state      out  3       current state code for LED/debug
// BEHAVIOUR
//  - All outputs registered. i_rst=0 forces, asynchronously: state IDLE, every output 0, counters 0, delay line cleared.
//  - State codes: IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4.
//  - IDLE:
//    - i_run=1 and i_imgLength!=0 -> RUN; latch len_q=i_imgLength, rcnt=0.
//    - i_run=1 and i_imgLength==0 -> DONE directly.
//    - else i_load=1 -> LOAD; wcnt=0.
//    - i_run has priority over i_load.
//  - LOAD:
//    - i_valid=1 in cycle n -> o_we=1 and o_waddr=wcnt in cycle n+1; then wcnt++.
//    - Wrap: wcnt==len-1 -> 0 (len sampled live); len==0 -> wcnt stays 0.
//    - i_load=0 and i_run=0 -> IDLE; an i_valid in that same cycle is dropped.
//    - i_run=1 -> RUN (same rules as IDLE, imgLength latched); an i_valid in that cycle is dropped.
//  - RUN: i_run sampled high in cycle n:
//    - o_rd_en=1 from n+1 through n+len_q, o_raddr=0..len_q-1, one per cycle.
//    - Then -> DRAIN; i_valid and i_load ignored.
//  - DRAIN: waits until the RUN_LAT-deep delay line of o_rd_en is empty, then -> DONE.
//    - o_out_valid high n+1+RUN_LAT .. n+len_q+RUN_LAT.
//    - o_EOP rises at n+len_q+RUN_LAT+1.
//  - DONE:
//    - o_EOP=1 held; it is not a pulse, because the control block clears run on it and blocks re-run while it is high.
//    - Leave DONE when i_run=0 and i_load=1 -> LOAD, wcnt=0, o_EOP=0 in the same cycle.
//    - i_run=1 in DONE keeps DONE (no re-trigger until a new load).
//  - len_q is frozen during RUN/DRAIN: imgLength changes mid-run have no effect.
//  - Reset mid-RUN/DRAIN aborts immediately: no further o_rd_en/o_out_valid, o_EOP=0.
//  - Max length 2^ADDR_W-1; counters never exceed len_q-1.
// TESTING
//  T1 reset:
//     - assert i_rst=0 mid-RUN with len=8 -> all outputs 0 same cycle.
//     - release -> o_state=0, no o_we/o_rd_en.
//  T2 load:
//     - imgLength=4, i_load=1, six i_valid pulses spaced 3 cycles.
//     - -> six o_we pulses one cycle after each; o_waddr 0,1,2,3,0,1.
//  T3 run:
//     - len=5, RUN_LAT=2, i_run high at cycle n.
//     - -> o_rd_en n+1..n+5, o_raddr 0..4; o_out_valid n+3..n+7; o_EOP high from n+8 and held.
//  T4 zero length: imgLength=0, i_run=1 from IDLE -> DONE next cycle, o_EOP=1, no o_rd_en ever.
//  T5 simultaneous:
//     - i_valid coincident with i_run rise in LOAD -> no o_we; RUN entered.
//     - imgLength changed 3->9 mid-RUN -> sweep still ends at raddr 2.
//  T6 restart:
//     - in DONE, i_run=1 alone -> stays DONE.
//     - then i_run=0, i_load=1 -> LOAD, o_EOP=0 next cycle, next o_we at o_waddr=0.

Source files
------------

// File: rtl/img_load_run_sequencer.sv
// img_load_run_sequencer
// Sits downstream of the control register block. In LOAD it turns each
// valid pulse into one memory write with an incrementing (wrapping) column
// address. In RUN it sweeps read addresses 0..len-1, then waits for the
// convolution pipeline to drain. Finally it holds end-of-processing high
// until a new load is requested.
module img_load_run_sequencer #(
   parameter int ADDR_W  = 10,
   parameter int RUN_LAT = 2
) (
   input  logic              i_CLK,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic              i_load,
   input  logic              i_run,
   input  logic [ADDR_W-1:0] i_imgLength,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_raddr,
   output logic              o_out_valid,
   output logic              o_EOP,
   output logic [2:0]        o_state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    len_q, len_d;
   logic [ADDR_W-1:0]    wcnt_q, wcnt_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    waddr_q, waddr_d;
   logic                 rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]    raddr_q, raddr_d;
   logic [RUN_LAT-1:0]   dly_q, dly_d;
   logic                 eop_q, eop_d;

   logic                 start_run;
   logic [ADDR_W-1:0]    wcnt_inc;

   // Next-state, counter and registered-output logic for the sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d   = state_q;
      len_d     = len_q;
      wcnt_d    = wcnt_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      rd_en_d   = 1'b0;
      raddr_d   = raddr_q;
      start_run = 1'b0;

      // Pipeline of o_rd_en; the oldest stage drives o_out_valid.
      dly_d = (dly_q << 1) | RUN_LAT'(rd_en_q);

      // Write column wraps against the live image length.
      if (i_imgLength == '0 || wcnt_q >= i_imgLength - ADDR_W'(1))
         wcnt_inc = '0;
      else
         wcnt_inc = wcnt_q + ADDR_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (i_run) begin
               start_run = 1'b1;
            end else if (i_load) begin
               state_d = ST_LOAD;
               wcnt_d  = '0;
            end
         end
         ST_LOAD: begin
            // A valid arriving in the same cycle as a mode change is dropped.
            if (i_run) begin
               start_run = 1'b1;
            end else if (!i_load) begin
               state_d = ST_IDLE;
            end else if (i_valid) begin
               we_d    = 1'b1;
               waddr_d = wcnt_q;
               wcnt_d  = wcnt_inc;
            end
         end
         ST_RUN: begin
            // len_q is at least 1 here; the last read was issued at len_q-1.
            if (raddr_q >= len_q - ADDR_W'(1)) begin
               state_d = ST_DRAIN;
            end else begin
               rd_en_d = 1'b1;
               raddr_d = raddr_q + ADDR_W'(1);
            end
         end
         ST_DRAIN: begin
            // Leave once the delay line will be empty next cycle.
            if (dly_d == '0)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            // Only a fresh load re-arms the sequencer; run alone is ignored.
            if (!i_run && i_load) begin
               state_d = ST_LOAD;
               wcnt_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Shared run-start handling for IDLE and LOAD; run beats load.
      if (start_run) begin
         if (i_imgLength == '0) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_RUN;
            len_d   = i_imgLength;
            raddr_d = '0;
            rd_en_d = 1'b1;
         end
      end

      eop_d = (state_d == ST_DONE);
   end

   // State, counters and all outputs are registered with asynchronous reset.
   always_ff @(posedge i_CLK or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         wcnt_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         rd_en_q <= 1'b0;
         raddr_q <= '0;
         dly_q   <= '0;
         eop_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q <= state_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         rd_en_q <= rd_en_d;
         raddr_q <= raddr_d;
         dly_q   <= dly_d;
         eop_q   <= eop_d;
      end
   end

   assign o_we        = we_q;
   assign o_waddr     = waddr_q;
   assign o_rd_en     = rd_en_q;
   assign o_raddr     = raddr_q;
   assign o_out_valid = dly_q[RUN_LAT-1];
   assign o_EOP       = eop_q;
   assign o_state     = state_q;

endmodule
